// File: rtl/polinomio_pkg.sv
// polinomio_pkg: shared widths, default watchdog limit and sequencer state encoding
package polinomio_pkg;
   localparam int X_W         = 8;
   localparam int D_W         = 16;
   localparam int TIMEOUT_DEF = 15;
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT_DONE = 2'd2} estado_t;
endpackage

// File: rtl/fifo_sincrono.sv
// fifo_sincrono: power-of-two synchronous FIFO with occupancy count
module fifo_sincrono #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int W      = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic [W-1:0]      din,
   output logic [W-1:0]      dout,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   fill
);
   logic [W-1:0]      mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [ADDR_W:0]   fill_q, fill_d;
   always_comb begin
      wr_d   = wr_q + ADDR_W'(push);
      rd_d   = rd_q + ADDR_W'(pop);
      fill_d = fill_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         fill_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         fill_q <= fill_d;
      end
   always_ff @(posedge clock)
      if (push) mem_q[wr_q] <= din;
   assign dout  = mem_q[rd_q];
   assign full  = fill_q == (ADDR_W+1)'(DEPTH);
   assign empty = fill_q == '0;
   assign fill  = fill_q;
endmodule

// File: rtl/sequenciador_polinomio.sv
// sequenciador_polinomio: feeds buffered x samples to the polynomial unit one at a time
// and returns each result on a valid/ready stream, with a sticky done watchdog.
module sequenciador_polinomio
   import polinomio_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 2,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              coef_load,
   input  logic [D_W-1:0]    coef_a,
   input  logic [D_W-1:0]    coef_b,
   input  logic [D_W-1:0]    coef_c,
   input  logic              x_valid,
   output logic              x_ready,
   input  logic [X_W-1:0]    x_data,
   output logic              y_valid,
   input  logic              y_ready,
   output logic [D_W-1:0]    y_data,
   output logic              enable,
   output logic [X_W-1:0]    valor_x,
   output logic [D_W-1:0]    valor_a,
   output logic [D_W-1:0]    valor_b,
   output logic [D_W-1:0]    valor_c,
   input  logic              unit_ready,
   input  logic              unit_done,
   input  logic [D_W-1:0]    resultado,
   output logic [ADDR_W:0]   fill,
   output logic              timeout_err
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   estado_t         st_q, st_d;
   logic [X_W-1:0]  vx_q, vx_d, head;
   logic [D_W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, yd_q, yd_d;
   logic            yv_q, yv_d, err_q, err_d, pop, full, empty;
   logic [WD_W-1:0] wd_q, wd_d;
   fifo_sincrono #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(X_W)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (x_valid && !full),
      .pop     (pop),
      .din     (x_data),
      .dout    (head),
      .full    (full),
      .empty   (empty),
      .fill    (fill)
   );
   always_comb begin
      st_d  = st_q;
      vx_d  = vx_q;
      a_d   = a_q;
      b_d   = b_q;
      c_d   = c_q;
      yv_d  = yv_q && !y_ready;
      yd_d  = yd_q;
      wd_d  = wd_q;
      err_d = err_q;
      pop   = 1'b0;
      if (st_q == IDLE) begin
         if (coef_load) begin
            a_d = coef_a;
            b_d = coef_b;
            c_d = coef_c;
         end
         if (!empty && unit_ready && !yv_q) begin
            st_d = START;
            vx_d = head;
         end
      end else if (st_q == START) begin
         st_d = WAIT_DONE;
         wd_d = '0;
      end else if (st_q == WAIT_DONE) begin
         wd_d = wd_q + 1'b1;
         // the sample leaves the FIFO only once its evaluation is finished or abandoned
         if (unit_done) begin
            yd_d = resultado;
            yv_d = 1'b1;
            pop  = 1'b1;
            st_d = IDLE;
         end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            err_d = 1'b1;
            pop   = 1'b1;
            st_d  = IDLE;
         end
      end else begin
         st_d = IDLE;
      end
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         st_q  <= IDLE;
         vx_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         yv_q  <= 1'b0;
         yd_q  <= '0;
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         vx_q  <= vx_d;
         a_q   <= a_d;
         b_q   <= b_d;
         c_q   <= c_d;
         yv_q  <= yv_d;
         yd_q  <= yd_d;
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   assign x_ready     = !full;
   assign enable      = st_q == START;
   assign valor_x     = vx_q;
   assign valor_a     = a_q;
   assign valor_b     = b_q;
   assign valor_c     = c_q;
   assign y_valid     = yv_q;
   assign y_data      = yd_q;
   assign timeout_err = err_q;
endmodule

// File: tb/tb_sequenciador_polinomio.sv
// tb_sequenciador_polinomio: scoreboard bench with a behavioural polynomial unit
module tb_sequenciador_polinomio;
   localparam int TIMEOUT = 15;
   logic        clock = 0, reset_n = 0, coef_load = 0, x_valid = 0, y_ready = 0;
   logic [15:0] coef_a = 0, coef_b = 0, coef_c = 0;
   logic [7:0]  x_data = 0;
   logic        x_ready, y_valid, enable, unit_ready, unit_done, timeout_err;
   logic [15:0] y_data, valor_a, valor_b, valor_c, resultado;
   logic [7:0]  valor_x;
   logic [2:0]  fill;

   sequenciador_polinomio #(.DEPTH(4), .ADDR_W(2), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset_n(reset_n), .coef_load(coef_load),
      .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
      .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
      .enable(enable), .valor_x(valor_x), .valor_a(valor_a), .valor_b(valor_b), .valor_c(valor_c),
      .unit_ready(unit_ready), .unit_done(unit_done), .resultado(resultado),
      .fill(fill), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   int n_cmp = 0, n_bad = 0, n_en = 0, max_fill = 0;
   bit en_prev = 0, rnd = 0, broken = 0, skip_vx = 0;
   longint ea = 0, eb = 0, ec = 0;
   logic [15:0] q[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] poly(input longint a, input longint b, input longint c, input longint x);
      return 16'(a * x * x + b * x + c);
   endfunction

   // behavioural unit: samples x one cycle after enable, done 7 cycles after enable, one busy cycle after done
   logic       busy = 0;
   int         cnt = 0;
   logic [7:0] ux = 0;
   always @(posedge clock) begin
      if (enable) begin
         busy <= 1;
         cnt  <= 1;
      end else if (busy) begin
         if (cnt == 1) ux <= valor_x;
         if (cnt >= 8) busy <= 0;
         else cnt <= cnt + 1;
      end
   end
   assign unit_ready = !busy;
   assign unit_done  = busy && cnt == 7 && !broken;
   assign resultado  = poly(longint'(valor_a), longint'(valor_b), longint'(valor_c), longint'(ux));

   // monitor / scoreboard
   always @(negedge clock) if (reset_n) begin
      if (enable) begin
         n_en++;
         if (en_prev) chk("enable_width", 2, 1);
      end
      en_prev = enable;
      if (int'(fill) > max_fill) max_fill = int'(fill);
      if (unit_done && !skip_vx) chk("valor_x_hold", valor_x, ux);
      if (y_valid && y_ready) begin
         if (q.size() == 0) chk("unexpected_y", y_data, -1);
         else chk("y_data", y_data, q.pop_front());
      end
   end

   task automatic tick;
      @(posedge clock); #1;
      if (rnd) y_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic load(input longint a, input longint b, input longint c);
      coef_a = 16'(a); coef_b = 16'(b); coef_c = 16'(c); coef_load = 1;
      tick;
      coef_load = 0;
      ea = a; eb = b; ec = c;
   endtask

   task automatic push(input int x, input bit exp_on);
      bit ok = 0;
      x_valid = 1; x_data = 8'(x);
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clock);
         ok = x_ready;
         tick;
      end
      x_valid = 0;
      if (!ok) chk("push_accept", 0, 1);
      else if (exp_on) q.push_back(poly(ea, eb, ec, longint'(x)));
   endtask

   task automatic drain;
      bit done = 0;
      rnd = 0; y_ready = 1;
      for (int i = 0; i < 500 && !done; i++) begin
         tick;
         done = q.size() == 0 && fill == 0 && !y_valid;
      end
      if (!done) chk("drain", 0, 1);
      repeat (12) tick;
   endtask

   task automatic wait_en(input int n0);
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clock); #1;
         seen = n_en != n0;
      end
      chk("enable_seen", seen, 1);
   endtask

   initial begin
      int n0, k;
      bit yv_seen;
      #12;
      chk("rst_fill", fill, 0);
      chk("rst_x_ready", x_ready, 1);
      chk("rst_y_valid", y_valid, 0);
      chk("rst_enable", enable, 0);
      chk("rst_valor_x", valor_x, 0);
      chk("rst_valor_a", valor_a, 0);
      chk("rst_timeout_err", timeout_err, 0);
      @(posedge clock); #1 reset_n = 1;

      // single sample
      load(1, 2, 3);
      y_ready = 1;
      n0 = n_en;
      push(2, 1);
      chk("single_expect", poly(ea, eb, ec, 2), 11);
      drain;
      chk("single_enables", n_en - n0, 1);
      chk("single_fill", fill, 0);

      // burst with backpressure
      y_ready = 0;
      n0 = n_en;
      for (int i = 1; i <= 4; i++) push(i, 1);
      @(negedge clock); #1;
      chk("burst_fill", fill, 4);
      chk("burst_x_ready", x_ready, 0);
      fork
         push(5, 1);
         begin
            repeat (30) tick;
            chk("burst_one_start", n_en - n0, 1);
            chk("burst_y_valid", y_valid, 1);
            chk("burst_y_hold", y_data, 6);
            y_ready = 1;
         end
      join
      drain;
      chk("burst_enables", n_en - n0, 5);

      // coefficient load while busy is ignored
      n0 = n_en;
      push(2, 1);
      wait_en(n0);
      repeat (3) tick;
      coef_a = 5; coef_b = 5; coef_c = 5; coef_load = 1;
      tick;
      coef_load = 0;
      chk("busy_load_a", valor_a, 1);
      drain;
      load(0, 0, 7);
      chk("idle_load_c", valor_c, 7);
      push(9, 1);
      drain;

      // watchdog
      broken = 1;
      n0 = n_en;
      push(4, 0);
      wait_en(n0);
      k = 0;
      while (!timeout_err && k < 60) begin
         @(negedge clock); #1;
         k++;
      end
      chk("timeout_cycles", k, TIMEOUT + 1);
      chk("timeout_fill", fill, 0);
      chk("timeout_no_y", y_valid, 0);
      broken = 0;
      drain;
      load(1, 2, 3);
      push(1, 1);
      drain;
      chk("timeout_sticky", timeout_err, 1);

      // async reset in the middle of an evaluation
      y_ready = 1;
      n0 = n_en;
      push(1, 1);
      push(2, 1);
      wait_en(n0);
      repeat (2) tick;
      chk("pre_reset_fill", fill, 2);
      #3 reset_n = 0;
      skip_vx = 1;
      q.delete();
      #1;
      chk("ar_fill", fill, 0);
      chk("ar_x_ready", x_ready, 1);
      chk("ar_y_valid", y_valid, 0);
      chk("ar_y_data", y_data, 0);
      chk("ar_valor_x", valor_x, 0);
      chk("ar_valor_a", valor_a, 0);
      chk("ar_timeout_err", timeout_err, 0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1;
      yv_seen = 0;
      repeat (15) begin
         tick;
         yv_seen |= y_valid;
      end
      chk("ar_done_ignored", yv_seen, 0);
      skip_vx = 0;

      // pointer wrap, one sample at a time
      load(0, 1, 0);
      max_fill = 0;
      for (int i = 0; i < 10; i++) begin
         push(i, 1);
         drain;
      end
      chk("wrap_max_fill", max_fill, 1);

      // randomized traffic
      for (int r = 0; r < 6; r++) begin
         load(longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)));
         rnd = 1;
         for (int s = 0; s < 6; s++) begin
            push(int'($urandom_range(0, 255)), 1);
            repeat ($urandom_range(0, 3)) tick;
         end
         drain;
      end
      chk("final_queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "time limit");
   end
endmodule
